add_arb: RTL and testbench

Round-robin scheduler that shares one `add_1p` pipelined adder between `N_REQ` requesters. Each requester offers an operand pair with a valid/ready handshake. The block grants at most one requester per cycle and issues its operands into the adder. It carries the requester index through a tag pipeline matched to the adder latency and returns each sum on a shared result bus tagged with that index. It sits between the arithmetic clients and the adder, and replaces per-client adder instances.

---
 rtl/add_arb_pkg.sv | 18 +
 rtl/add_1p.sv | 23 ++
 rtl/add_arb_rr_arb.sv | 37 +++
 rtl/add_arb.sv | 120 ++++++++++++
 tb/tb_add_arb.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared constants and index-width helper for the add_arb scheduler
package add_arb_pkg;

  localparam int W_DEF     = 15;
  localparam int N_REQ_MAX = 8;
  localparam int CNT_W     = 16;

  // Width of a requester index; never less than one bit.
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 32; k++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/add_1p.sv
// rtl/add_1p.sv - pipelined W-bit adder without reset, carry-out discarded
module add_1p #(
  parameter int W   = 15,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum
);

  logic [W-1:0] stg [LAT];

  always_ff @(posedge clk) begin
    stg[0] <= x + y;
    for (int i = 1; i < LAT; i++) begin
      stg[i] <= stg[i-1];
    end
  end

  assign sum = stg[LAT-1];

endmodule

// File: rtl/add_arb_rr_arb.sv
// rtl/add_arb_rr_arb.sv - combinational round-robin grant starting at ptr
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  input  logic             hold,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    gidx,
  output logic             gvld
);

  int   j;
  logic found;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    if (!hold) begin
      for (int k = 0; k < N_REQ; k++) begin
        j = (int'(ptr) + k) % N_REQ;
        if (!found && valid[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          gidx     = IW'(j);
        end
      end
    end
  end

  assign gvld = found;

endmodule

// File: rtl/add_arb.sv
// rtl/add_arb.sv - round-robin sharing of one pipelined adder across N_REQ requesters
module add_arb
  import add_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = W_DEF,
  parameter int ADD_LAT = 1,
  localparam int IW     = idx_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  output logic [IW-1:0]      res_id,
  output logic [W-1:0]       res_sum,
  output logic               idle,
  output logic [CNT_W-1:0]   n_issued
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic          accept;
  logic [W-1:0]  x_sel, y_sel;

  logic          iss_v;
  logic [IW-1:0] iss_id;
  logic [W-1:0]  iss_x, iss_y;

  logic [ADD_LAT-1:0] tag_v;
  logic [IW-1:0]      tag_id [ADD_LAT];
  logic [W-1:0]       add_sum;

  // Reset gates grants the same way hold does, so nothing is accepted during reset.
  rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .hold  (hold | rst),
    .grant (req_ready),
    .gidx  (gidx),
    .gvld  (accept)
  );

  assign x_sel = req_x[int'(gidx)*W +: W];
  assign y_sel = req_y[int'(gidx)*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      n_issued <= '0;
    end else if (accept) begin
      ptr      <= (gidx == IW'(N_REQ-1)) ? '0 : gidx + 1'b1;
      n_issued <= n_issued + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_v  <= 1'b0;
      iss_id <= '0;
      iss_x  <= '0;
      iss_y  <= '0;
    end else begin
      iss_v <= accept;
      if (accept) begin
        iss_id <= gidx;
        iss_x  <= x_sel;
        iss_y  <= y_sel;
      end
    end
  end

  add_1p #(
    .W   (W),
    .LAT (ADD_LAT)
  ) u_add (
    .clk (clk),
    .x   (iss_x),
    .y   (iss_y),
    .sum (add_sum)
  );

  // Tag pipeline tracks the adder stage by stage; only its valid bits qualify results.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < ADD_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= iss_v;
      tag_id[0] <= iss_id;
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
    end else begin
      res_valid <= tag_v[ADD_LAT-1];
      if (tag_v[ADD_LAT-1]) begin
        res_id  <= tag_id[ADD_LAT-1];
        res_sum <= add_sum;
      end
    end
  end

  assign idle = !(iss_v || (|tag_v) || res_valid);

endmodule

// File: tb/tb_add_arb.sv
// tb/tb_add_arb.sv - randomized self-checking bench for add_arb against a queue-based model
module tb_add_arb;

  localparam int N    = 4;
  localparam int W    = 15;
  localparam int LAT  = 1;
  localparam int IW   = 2;
  localparam int MASK = (1 << W) - 1;

  logic             clk = 1'b0;
  logic             rst, hold;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_x, req_y;
  logic [N-1:0]     req_ready;
  logic             res_valid;
  logic [IW-1:0]    res_id;
  logic [W-1:0]     res_sum;
  logic             idle;
  logic [15:0]      n_issued;

  always #5 clk = ~clk;

  add_arb #(.N_REQ(N), .W(W), .ADD_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .idle      (idle),
    .n_issued  (n_issued)
  );

  typedef struct {
    int id;
    int sum;
    int due;
  } res_t;

  int checks = 0;
  int errors = 0;

  res_t q[$];
  int   mptr    = 0;
  int   mn      = 0;
  int   edgecnt = 0;

  logic         d_rst, d_hold;
  logic [N-1:0] d_valid;
  int           xs [N];
  int           ys [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at edge %0d", tag, obs, exp, edgecnt);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p, input logic r, input logic h);
    if (r || h) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    int   g;
    logic [N-1:0] eg;
    res_t e;
    @(negedge clk);
    check("idle", 32'(idle), 32'(q.size() == 0));
    check("n_issued", 32'(n_issued), 32'(mn));
    if (q.size() > 0 && q[0].due == edgecnt) begin
      e = q.pop_front();
      check("res_valid", 32'(res_valid), 1);
      check("res_id", 32'(res_id), 32'(e.id));
      check("res_sum", 32'(res_sum), 32'(e.sum));
    end else begin
      check("res_valid", 32'(res_valid), 0);
    end
    rst       = d_rst;
    hold      = d_hold;
    req_valid = d_valid;
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = W'(xs[i]);
      req_y[i*W +: W] = W'(ys[i]);
    end
    #1;
    g  = pick(d_valid, mptr, d_rst, d_hold);
    eg = (g < 0) ? '0 : N'(1 << g);
    check("req_ready", 32'(req_ready), 32'(eg));
    @(posedge clk);
    edgecnt++;
    if (d_rst) begin
      q.delete();
      mptr = 0;
      mn   = 0;
    end else if (g >= 0) begin
      e.id  = g;
      e.sum = (xs[g] + ys[g]) % (1 << W);
      e.due = edgecnt + LAT + 1;
      q.push_back(e);
      mptr = (g + 1) % N;
      mn   = (mn + 1) % 65536;
    end
  endtask

  task automatic set_all(input int x, input int y);
    for (int i = 0; i < N; i++) begin
      xs[i] = x;
      ys[i] = y;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
    d_rst = 1'b0; d_hold = 1'b0; d_valid = '0;
    set_all(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_id", 32'(res_id), 0);
    check("rst_res_sum", 32'(res_sum), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_n_issued", 32'(n_issued), 0);
    check("rst_ready", 32'(req_ready), 0);
    @(posedge clk);

    // single op from requester 0
    xs[0] = 10; ys[0] = 0; d_valid = 4'b0001;
    tick();
    d_valid = '0;
    run(5);

    // full contention
    set_all(2002, 2002); d_valid = '1;
    run(12);

    // boundary sums, including carry drop
    d_valid = '0; xs[2] = 2047; ys[2] = 2047; xs[1] = 32767; ys[1] = 1;
    d_valid = 4'b0100; tick();
    d_valid = 4'b0010; tick();
    d_valid = '0; run(4);

    // hold with everyone valid, then release at saved ptr
    d_valid = '1; set_all(7, 9); tick(); tick();
    d_hold = 1'b1; run(6);
    d_hold = 1'b0; run(3);

    // reset with ops in flight
    d_rst = 1'b1; tick();
    d_rst = 1'b0; d_valid = '0; run(4);
    d_valid = '1; run(2);
    d_valid = '0; run(4);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = int'($urandom & MASK);
        ys[i] = int'($urandom & MASK);
      end
      d_valid = N'($urandom);
      d_hold  = ($urandom_range(0, 9) == 0);
      d_rst   = ($urandom_range(0, 49) == 0);
      tick();
    end
    d_rst = 1'b0; d_hold = 1'b0; d_valid = '0;
    run(4);

    // counter wrap: 65536 accepts from reset
    d_rst = 1'b1; tick();
    d_rst = 1'b0; d_valid = '1; set_all(1, 2);
    run(65536);
    d_valid = '0;
    run(4);
    check("n_issued_wrap", 32'(n_issued), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
